// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit: opcodes, functs,
// ALU operations, FSM states and datapath mux selects.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_R31 = 2'd2;
  localparam logic [1:0] RIN_ALUOUT = 2'd0, RIN_MDR = 2'd1, RIN_PC = 2'd2;
  localparam logic [1:0] SRCA_PC = 2'd0, SRCA_A = 2'd1;
  localparam logic [1:0] SRCB_B = 2'd0, SRCB_FOUR = 2'd1, SRCB_IMM = 2'd2, SRCB_BROFF = 2'd3;
  localparam logic [1:0] PCS_ALU = 2'd0, PCS_JUMP = 2'd1, PCS_REG = 2'd2, PCS_ALUOUT = 2'd3;

  function automatic logic is_supported(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: is_supported = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_SLT) || (fn == FN_JR);
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_XORI, OP_LW, OP_SW: is_supported = 1'b1;
      default:  is_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control/datapath boundary. Handshake: mem_ready high in a FETCH or MEM cycle means
// the access completes at the next rising edge; the controller never waits on other states.
interface multicycle_ctrl_fsm_if #(parameter int ALUOPW = 3);
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic              zero;
  logic              mem_ready;
  logic              pc_we, ir_we, mem_we, reg_we, a_we, b_we;
  logic              mem_in;
  logic [1:0]        reg_dst, reg_in, alu_src_a, alu_src_b, pc_src;
  logic [ALUOPW-1:0] alu_op;
  logic [2:0]        state;
  logic              instr_done, illegal, bus_err;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_we, ir_we, mem_we, reg_we, a_we, b_we, mem_in, reg_dst, reg_in,
           alu_src_a, alu_src_b, alu_op, pc_src, state, instr_done, illegal, bus_err
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_we, ir_we, mem_we, reg_we, a_we, b_we, mem_in, reg_dst, reg_in,
           alu_src_a, alu_src_b, alu_op, pc_src, state, instr_done, illegal, bus_err
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_mem_wait.sv
// Memory wait counter: counts stalled cycles in a waiting state and flags expiry.
module mem_wait_timer #(parameter int TIMEOUT = 15) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic ready,
  output logic expired
);
  logic [7:0] cnt_q, cnt_d;

  // Any cycle that is not a continuing stall returns the count to zero, so every
  // entry into a waiting state starts from a clean count.
  always_comb begin
    expired = waiting && !ready && (cnt_q == 8'(TIMEOUT));
    cnt_d   = (waiting && !ready && !expired) ? cnt_q + 8'd1 : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS-subset control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives
// all datapath enables and selects, with memory-ready handshake and bus timeout.
module multicycle_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOPW        = 3,
  parameter int MEM_HANDSHAKE = 1,
  parameter int TIMEOUT       = 15
) (
  input logic                  clk,
  input logic                  rst_n,
  multicycle_ctrl_fsm_if.master bus
);
  state_e     state_q, state_d;
  logic       rdy, waiting, expired;
  logic       pc_we_c, ir_we_c, mem_we_c, reg_we_c, a_we_c, b_we_c;
  logic       done_c, illegal_c, bus_err_c, mem_in_c;
  logic [1:0] reg_dst_c, reg_in_c, src_a_c, src_b_c, pc_src_c;
  logic [2:0] alu_c;

  assign rdy     = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;
  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk), .rst_n(rst_n), .waiting(waiting), .ready(rdy), .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pc_we_c  = 1'b0; ir_we_c = 1'b0; mem_we_c = 1'b0; reg_we_c = 1'b0;
    a_we_c   = 1'b0; b_we_c = 1'b0; done_c = 1'b0; illegal_c = 1'b0;
    bus_err_c = 1'b0; mem_in_c = 1'b0;
    reg_dst_c = DST_RT; reg_in_c = RIN_ALUOUT; src_a_c = SRCA_PC;
    src_b_c   = SRCB_B; pc_src_c = PCS_ALU;   alu_c   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        src_b_c = SRCB_FOUR;
        if (expired) begin
          bus_err_c = 1'b1; done_c = 1'b1;
        end else if (rdy) begin
          ir_we_c = 1'b1; pc_we_c = 1'b1; state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        src_b_c = SRCB_BROFF;
        state_d = S_FETCH;
        if (!is_supported(bus.opcode, bus.funct)) begin
          illegal_c = 1'b1; done_c = 1'b1;
        end else begin
          a_we_c = 1'b1; b_we_c = 1'b1;
          if (bus.opcode == OP_J || bus.opcode == OP_JAL) begin
            pc_we_c = 1'b1; pc_src_c = PCS_JUMP; done_c = 1'b1;
            if (bus.opcode == OP_JAL) begin
              reg_we_c = 1'b1; reg_dst_c = DST_R31; reg_in_c = RIN_PC;
            end
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        src_a_c = SRCA_A;
        state_d = S_FETCH;
        case (bus.opcode)
          OP_RTYPE: begin
            if (bus.funct == FN_JR) begin
              src_a_c = SRCA_PC; pc_we_c = 1'b1; pc_src_c = PCS_REG; done_c = 1'b1;
            end else begin
              alu_c   = (bus.funct == FN_SUB) ? ALU_SUB :
                        (bus.funct == FN_SLT) ? ALU_SLT : ALU_ADD;
              state_d = S_WB;
            end
          end
          OP_ADDI, OP_XORI: begin
            src_b_c = SRCB_IMM;
            alu_c   = (bus.opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            src_b_c = SRCB_IMM; state_d = S_MEM;
          end
          OP_BEQ, OP_BNE: begin
            alu_c    = ALU_SUB; pc_src_c = PCS_ALUOUT; done_c = 1'b1;
            pc_we_c  = (bus.opcode == OP_BEQ) ? bus.zero : !bus.zero;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_in_c = 1'b1;
        if (expired) begin
          bus_err_c = 1'b1; done_c = 1'b1; state_d = S_FETCH;
        end else if (bus.opcode == OP_SW) begin
          mem_we_c = 1'b1;
          if (rdy) begin
            done_c = 1'b1; state_d = S_FETCH;
          end
        end else if (rdy) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        reg_we_c  = 1'b1; done_c = 1'b1; state_d = S_FETCH;
        reg_dst_c = (bus.opcode == OP_RTYPE) ? DST_RD : DST_RT;
        reg_in_c  = (bus.opcode == OP_LW) ? RIN_MDR : RIN_ALUOUT;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // While reset is held no strobe may reach the datapath, even from the FETCH decode.
  assign bus.pc_we      = pc_we_c   & rst_n;
  assign bus.ir_we      = ir_we_c   & rst_n;
  assign bus.mem_we     = mem_we_c  & rst_n;
  assign bus.reg_we     = reg_we_c  & rst_n;
  assign bus.a_we       = a_we_c    & rst_n;
  assign bus.b_we       = b_we_c    & rst_n;
  assign bus.instr_done = done_c    & rst_n;
  assign bus.illegal    = illegal_c & rst_n;
  assign bus.bus_err    = bus_err_c & rst_n;
  assign bus.mem_in     = mem_in_c;
  assign bus.reg_dst    = reg_dst_c;
  assign bus.reg_in     = reg_in_c;
  assign bus.alu_src_a  = src_a_c;
  assign bus.alu_src_b  = src_b_c;
  assign bus.pc_src     = pc_src_c;
  assign bus.alu_op     = ALUOPW'(alu_c);
  assign bus.state      = state_q;
endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Control unit for the multi-cycle MIPS-subset CPU.
- Owns the state register and sequences FETCH/DECODE/EXEC/MEM/WB per instruction.
- Drives all datapath write enables and mux selects, with a memory ready handshake and a timeout.
- Successor to the state-indexed control table: adds internal sequencing, variable-latency memory, direct branch resolution, illegal-opcode and bus-error reporting.

Parameters:
- ALUOPW, 3, width of alu_op; encodings ADD=0, SUB=1, XOR=2, SLT=3.
- MEM_HANDSHAKE, 1, 1: obey mem_ready; 0: treat mem_ready as always 1.
- TIMEOUT, 15, maximum wait cycles in one memory state before bus_err; range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, same cycle.
- mem_ready  in  1  memory access completes this cycle.
- pc_we, ir_we, mem_we, reg_we, a_we, b_we  out  1  write enables.
- mem_in  out  1  memory address select: 0 PC, 1 ALUOut.
- reg_dst  out  2  write register select: 0 rt, 1 rd, 2 r31.
- reg_in  out  2  write data select: 0 ALUOut, 1 MDR, 2 PC.
- alu_src_a  out  2  0 PC, 1 A.
- alu_src_b  out  2  0 B, 1 const 4, 2 imm (sign-extended; zero-extended for XORI), 3 sext(imm)<<2.
- alu_op  out  ALUOPW  ALU operation.
- pc_src  out  2  0 ALU result, 1 {PC[31:28],addr,2'b00}, 2 A, 3 ALUOut.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal  out  1  pulse in DECODE on an unsupported opcode or funct.
- bus_err  out  1  pulse when the memory timeout expires.

Behaviour:
- State register and wait counter are the only flops. Outputs are combinational from state, opcode, funct, zero and mem_ready.
- Reset (rst_n low): state=FETCH, counter=0. All write enables, instr_done, illegal and bus_err are forced 0. Selects default to 0.
- Unlisted selects are 0 and unlisted enables are 0 in every state.
- FETCH: mem_in=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0. If mem_ready: ir_we=1, pc_we=1, go to DECODE. Otherwise hold, with ir_we=pc_we=0.
- DECODE: a_we=b_we=1; alu_src_a=0, alu_src_b=3, ADD (branch target into ALUOut).
  - J: pc_we=1, pc_src=1, done, go to FETCH.
  - JAL: pc_we=1, pc_src=1, reg_we=1, reg_dst=2, reg_in=2, done, go to FETCH. The PC already holds PC+4, so the link value is PC+4.
  - Unsupported opcode/funct: illegal=1, done, go to FETCH. No other enables.
  - Otherwise go to EXEC.
- Supported set: LW 0x23, SW 0x2B, J 0x02, JAL 0x03, BEQ 0x04, BNE 0x05, ADDI 0x08, XORI 0x0E; RTYPE funct ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08.
- EXEC:
  - RTYPE arith: alu_src_a=1, alu_src_b=0, alu_op from funct, go to WB.
  - JR: pc_we=1, pc_src=2, done, go to FETCH.
  - ADDI/XORI: alu_src_a=1, alu_src_b=2, ADD/XOR, go to WB.
  - LW/SW: alu_src_a=1, alu_src_b=2, ADD, go to MEM.
  - BEQ/BNE: alu_src_a=1, alu_src_b=0, SUB, pc_src=3. pc_we = zero for BEQ, !zero for BNE. Done, go to FETCH.
- MEM: mem_in=1.
  - SW: mem_we=1 held until mem_ready, then done, go to FETCH.
  - LW: on mem_ready go to WB.
- WB: reg_we=1.
  - RTYPE: reg_dst=1, reg_in=0.
  - ADDI/XORI: reg_dst=0, reg_in=0.
  - LW: reg_dst=0, reg_in=1.
  - Done, go to FETCH.
- Wait counter:
  - Clears on entry to FETCH or MEM.
  - Increments each cycle spent in FETCH or MEM with mem_ready=0.
  - When the counter reaches TIMEOUT with mem_ready still 0: bus_err=1, instr_done=1, go to FETCH, with no write enables that cycle.
  - mem_ready in the same cycle as the timeout wins: normal completion, no bus_err.
- Illegal state encodings 5..7 return to FETCH next cycle with all enables 0.
- Reset asserted mid-instruction aborts it immediately (asynchronous). No partial writes occur after rst_n falls.

Decomposition:
- Shared package `mips_ctrl_pkg`: opcode/funct constants, ALU op encodings, state encodings, and mux select encodings for reg_dst, reg_in, alu_src_a/b and pc_src.
- One sub-module, `mem_wait_timer`: counter plus timeout compare, parametrised by TIMEOUT.

Test Plan:
- ADD r3,r1,r2 with mem_ready=1: FETCH, DECODE, EXEC (alu_op=0), WB (reg_we=1, reg_dst=1); 4 cycles, instr_done in WB.
- LW with mem_ready low for 3 cycles in MEM: mem_in=1 held 4 cycles; then WB with reg_in=1, reg_we=1; total 8 cycles.
- BEQ with zero=1: pc_we=1 in EXEC. BNE with zero=1: pc_we=0. Both return to FETCH after 3 cycles.
- JAL: DECODE asserts pc_we, reg_we, reg_dst=2, reg_in=2, pc_src=1; next state FETCH. Opcode 0x3F: illegal pulse, no enables.
- TIMEOUT=4, SW with mem_ready stuck 0: mem_we high for 4 cycles, then bus_err and instr_done, mem_we=0, state=FETCH.
- rst_n low during MEM of SW: mem_we drops to 0 asynchronously; state=FETCH after release.
